// File: rtl/regfile_param.sv
// regfile_param: parameterized register file with two bypassable read ports, a debug read port and a soft clear
module regfile_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteRegister,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic [ADDR_WIDTH-1:0] ReadRegister1,
  input  logic [ADDR_WIDTH-1:0] ReadRegister2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic [ADDR_WIDTH-1:0] DebugRegister,
  output logic [DATA_WIDTH-1:0] DebugData,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clear_done
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic wr_en;
  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
    return is_zero(a) ? '0 : (BYPASS != 0 && wr_en && a == WriteRegister) ? WriteData : regs[a];
  endfunction
  assign busy = state != IDLE;
  assign clear_done = state == DONE;
  assign wr_en = RegWrite && !busy && !is_zero(WriteRegister);
  assign ReadData1 = rd(ReadRegister1);
  assign ReadData2 = rd(ReadRegister2);
  assign DebugData = is_zero(DebugRegister) ? '0 : regs[DebugRegister];
  always_comb begin
    state_nxt = state == IDLE ? (clear_req ? CLEAR : IDLE) :
                state == CLEAR ? (&cnt ? DONE : CLEAR) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      regs <= '{default: '0};
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        regs[cnt] <= '0;
        cnt <= cnt + 1'b1;
      end else if (state == IDLE && clear_req) begin
        cnt <= '0;
      end
      if (wr_en) regs[WriteRegister] <= WriteData;
    end
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for regfile_param in default, no-bypass and narrow configurations
module tb_regfile_param;
  logic clk = 0;
  logic reset;
  logic RegWrite, clear_req;
  logic [4:0] wa, ra1, ra2, dbg;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, dd, nb_rd1, nb_rd2, nb_dd;
  logic busy, done, nb_busy, nb_done;
  logic s_we, s_cr, s_busy, s_done;
  logic [2:0] s_wa, s_ra1, s_ra2, s_dbg;
  logic [15:0] s_wd, s_rd1, s_rd2, s_dd;
  int nchk = 0;
  int npass = 0;
  typedef struct {string name; int sel; logic [31:0] exp;} exp_t;
  exp_t q[$];
  exp_t e;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(rd1), .ReadData2(rd2),
    .DebugRegister(dbg), .DebugData(dd), .clear_req(clear_req), .busy(busy), .clear_done(done)
  );

  regfile_param #(.BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite(RegWrite), .WriteRegister(wa), .WriteData(wd),
    .ReadRegister1(ra1), .ReadRegister2(ra2), .ReadData1(nb_rd1), .ReadData2(nb_rd2),
    .DebugRegister(dbg), .DebugData(nb_dd), .clear_req(clear_req), .busy(nb_busy), .clear_done(nb_done)
  );

  regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
    .clk(clk), .reset(reset), .RegWrite(s_we), .WriteRegister(s_wa), .WriteData(s_wd),
    .ReadRegister1(s_ra1), .ReadRegister2(s_ra2), .ReadData1(s_rd1), .ReadData2(s_rd2),
    .DebugRegister(s_dbg), .DebugData(s_dd), .clear_req(s_cr), .busy(s_busy), .clear_done(s_done)
  );

  function automatic logic [31:0] actual(input int s);
    case (s)
      0: return rd1;
      1: return rd2;
      2: return dd;
      3: return {31'b0, busy};
      4: return {31'b0, done};
      5: return nb_rd1;
      6: return nb_dd;
      7: return {16'b0, s_rd1};
      8: return {31'b0, s_busy};
      9: return {31'b0, s_done};
      default: return 'x;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      nchk++;
      if (actual(e.sel) === e.exp) npass++;
      else $display("FAIL %s: got %h expected %h", e.name, actual(e.sel), e.exp);
    end
  end

  task automatic chk(input string n, input int s, input logic [31:0] x);
    q.push_back('{n, s, x});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1; RegWrite = 0; clear_req = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; dbg = 0;
    s_we = 0; s_cr = 0; s_wa = 0; s_wd = 0; s_ra1 = 0; s_ra2 = 0; s_dbg = 0;
    cyc();
    chk("rst_busy", 3, 0); chk("rst_done", 4, 0); chk("rst_rd1", 0, 0);
    cyc();
    reset = 0;
    RegWrite = 1; wa = 5; wd = 32'hDEADBEEF;
    cyc();
    RegWrite = 0; ra1 = 5; ra2 = 5; dbg = 5;
    chk("r5_rd1", 0, 32'hDEADBEEF); chk("r5_rd2", 1, 32'hDEADBEEF);
    chk("r5_dbg", 2, 32'hDEADBEEF); chk("r5_nb_rd1", 5, 32'hDEADBEEF);
    cyc();
    RegWrite = 1; wa = 7; wd = 32'h11111111;
    cyc();
    wd = 32'h12345678; ra1 = 7; dbg = 7;
    chk("byp_rd1", 0, 32'h12345678); chk("nobyp_rd1", 5, 32'h11111111);
    chk("byp_dbg", 2, 32'h11111111); chk("nobyp_dbg", 6, 32'h11111111);
    cyc();
    RegWrite = 0;
    chk("r7_rd1", 0, 32'h12345678); chk("r7_nb_rd1", 5, 32'h12345678);
    cyc();
    RegWrite = 1; wa = 0; wd = 32'hFFFFFFFF; ra1 = 0; dbg = 0; ra2 = 5;
    chk("r0_wr_rd1", 0, 0); chk("r0_wr_dbg", 2, 0); chk("r0_wr_nb_rd1", 5, 0);
    chk("r0_wr_rd2", 1, 32'hDEADBEEF);
    cyc();
    RegWrite = 0;
    chk("r0_rd1", 0, 0); chk("r0_dbg", 2, 0);
    for (int i = 1; i < 32; i++) begin
      cyc();
      RegWrite = 1; wa = 5'(i); wd = 32'h01010101 * i;
    end
    cyc();
    RegWrite = 1; wa = 9; wd = 32'h99; clear_req = 1; ra1 = 9; ra2 = 3;
    chk("clr_req_busy", 3, 0); chk("clr_req_byp", 0, 32'h99); chk("fill_r3", 1, 32'h03030303);
    for (int k = 1; k <= 33; k++) begin
      cyc();
      clear_req = (k == 5); RegWrite = (k == 10); wa = 3; wd = 32'hAAAAAAAA;
      ra1 = (k == 1) ? 5'd9 : 5'd3; ra2 = 20;
      chk($sformatf("clr_busy_%0d", k), 3, 1);
      chk($sformatf("clr_done_%0d", k), 4, {31'b0, k == 33});
      if (k == 1) chk("clr_r9_kept", 0, 32'h99);
      if (k == 10) begin
        chk("clr_r3_blocked", 0, 0); chk("clr_r20_old", 1, 32'h14141414);
      end
      if (k == 22) chk("clr_r20_zero", 1, 0);
    end
    cyc();
    RegWrite = 0; clear_req = 0;
    chk("post_clr_busy", 3, 0); chk("post_clr_done", 4, 0);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); dbg = 5'(31 - i);
      chk($sformatf("post_clr_rd1_%0d", i), 0, 0); chk($sformatf("post_clr_dbg_%0d", 31 - i), 2, 0);
      cyc();
    end
    RegWrite = 1; wa = 25; wd = 32'h25252525;
    cyc();
    RegWrite = 0; clear_req = 1; ra1 = 25;
    chk("r25_set", 0, 32'h25252525);
    for (int k = 1; k <= 11; k++) begin
      cyc();
      clear_req = 0;
      chk($sformatf("abort_busy_%0d", k), 3, 1);
    end
    cyc();
    reset = 1;
    chk("abort_busy", 3, 0); chk("abort_done", 4, 0); chk("abort_r25", 0, 0);
    cyc();
    chk("abort_done2", 4, 0);
    reset = 0; RegWrite = 1; wa = 4; wd = 32'h44444444;
    cyc();
    RegWrite = 0; ra1 = 4;
    chk("r4_after_rst", 0, 32'h44444444); chk("r4_busy", 3, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("no_done_%0d", k), 4, 0);
    end
    s_we = 1; s_wa = 3; s_wd = 16'hBEEF;
    cyc();
    s_wa = 7; s_wd = 16'h1234;
    cyc();
    s_we = 0; s_ra1 = 3;
    chk("s_r3", 7, 32'hBEEF);
    cyc();
    s_ra1 = 7; s_cr = 1;
    chk("s_r7", 7, 32'h1234); chk("s_req_busy", 8, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      s_cr = 0;
      chk($sformatf("s_busy_%0d", k), 8, 1);
      chk($sformatf("s_done_%0d", k), 9, {31'b0, k == 9});
    end
    cyc();
    chk("s_post_busy", 8, 0); chk("s_post_r7", 7, 0);
    cyc();
    cyc();
    @(negedge clk);
    nchk++;
    if (busy === 1'b0) npass++;
    else $display("FAIL final_busy: got %b expected 0", busy);
    nchk++;
    if (done === 1'b0) npass++;
    else $display("FAIL final_done: got %b expected 0", done);
    nchk++;
    if (rd1 === 32'h44444444) npass++;
    else $display("FAIL final_r4: got %h expected 44444444", rd1);
    nchk++;
    if (dd === 32'h0) npass++;
    else $display("FAIL final_dbg: got %h expected 0", dd);
    nchk++;
    if (s_busy === 1'b0) npass++;
    else $display("FAIL final_s_busy: got %b expected 0", s_busy);
    nchk++;
    if (s_rd1 === 16'h0) npass++;
    else $display("FAIL final_s_r7: got %h expected 0", s_rd1);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 5, register index width; depth = 2^ADDR_WIDTH.
REQ-003 SHALL provide parameter ZERO_REG, default 1: when 1, register 0 always reads 0 and ignores writes.
REQ-004 SHALL provide parameter BYPASS, default 1: when 1, same-cycle write data forwards to the read ports.
REQ-005 SHALL provide port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL provide port RegWrite, input, 1, write enable.
REQ-008 SHALL provide port WriteRegister, input, ADDR_WIDTH, write index.
REQ-009 SHALL provide port WriteData, input, DATA_WIDTH, write data.
REQ-010 SHALL provide ports ReadRegister1 and ReadRegister2, input, ADDR_WIDTH, read indices.
REQ-011 SHALL provide ports ReadData1 and ReadData2, output, DATA_WIDTH, read data.
REQ-012 SHALL provide port DebugRegister, input, ADDR_WIDTH, debug read index.
REQ-013 SHALL provide port DebugData, output, DATA_WIDTH, debug read data, never bypassed.
REQ-014 SHALL provide port clear_req, input, 1, soft-clear request, sampled on clk.
REQ-015 SHALL provide port busy, output, 1, high while the soft clear is running.
REQ-016 SHALL provide port clear_done, output, 1, one-cycle pulse when the soft clear completes.

Function
REQ-017 Read ports SHALL be combinational: ReadDataN = register[ReadRegisterN], with zero latency.
REQ-018 With ZERO_REG=1, any read of index 0 SHALL return 0, including bypass and debug reads.
REQ-019 A write SHALL commit on the rising clk edge when RegWrite=1, busy=0, and (ZERO_REG=0 or WriteRegister!=0).
REQ-020 With BYPASS=1, busy=0, RegWrite=1 and ReadRegisterN==WriteRegister, ReadDataN SHALL equal WriteData in the same cycle, subject to REQ-018.
REQ-021 With BYPASS=0, reads SHALL return the pre-edge register contents.
REQ-022 The FSM SHALL have states IDLE, CLEAR and DONE.
REQ-023 IDLE -> CLEAR SHALL occur on the edge where clear_req=1 in IDLE; the index counter loads 0.
REQ-024 In CLEAR, each edge SHALL zero register[counter] and increment the counter.
REQ-025 CLEAR -> DONE SHALL occur on the edge that zeroes index 2^ADDR_WIDTH-1; the counter wraps to 0.
REQ-026 DONE -> IDLE SHALL occur unconditionally after one cycle.
REQ-027 busy SHALL be 1 in CLEAR and DONE, and 0 in IDLE.
REQ-028 clear_done SHALL be 1 only in DONE.
REQ-029 A full clear SHALL take 2^ADDR_WIDTH cycles in CLEAR plus 1 in DONE; busy rises the cycle after clear_req is sampled.
REQ-030 RegWrite while busy=1 SHALL be dropped silently; clear_req while busy=1 SHALL be ignored.
REQ-031 If clear_req=1 and RegWrite=1 on the same IDLE edge, the write SHALL commit and the clear SHALL start; the clear later zeroes that register.
REQ-032 During CLEAR, reads SHALL return current array contents: 0 for already-cleared indices, old data otherwise.

Reset
REQ-033 reset=1 SHALL immediately, without waiting for clk, zero all registers, force the FSM to IDLE, zero the counter, and drive busy=0 and clear_done=0.
REQ-034 reset asserted mid-clear SHALL abort the clear; no clear_done pulse is produced.
REQ-035 After reset deasserts, the first rising edge SHALL accept writes and clear_req normally.

Verification
REQ-036 Write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> ReadData1 = ReadData2 = 0xDEADBEEF; DebugRegister=5 -> DebugData = 0xDEADBEEF.
REQ-037 RegWrite=1, WriteRegister=7, WriteData=0x12345678, ReadRegister1=7, same cycle -> ReadData1 = 0x12345678 with BYPASS=1; previous value with BYPASS=0; DebugData (index 7) shows previous value.
REQ-038 Write 0xFFFFFFFF to r0 with ZERO_REG=1 -> ReadData1 (index 0) = 0 and DebugData (index 0) = 0, including during the write cycle.
REQ-039 Fill r1..r31 with nonzero data, pulse clear_req -> busy=1 for 33 cycles, clear_done high on the 33rd, all reads 0 afterwards; a RegWrite to r3 at cycle 10 has no effect.
REQ-040 Start a clear, assert reset at CLEAR cycle 12 -> busy=0 and all registers 0 immediately, no clear_done pulse; a write to r4 after release commits.
REQ-041 Instantiate with DATA_WIDTH=16, ADDR_WIDTH=3 -> writes and reads work on 8 registers; a clear takes 8+1 cycles.
